// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge.
package apb_pkg;

    localparam int unsigned ADDR_W_DFLT = 32;
    localparam int unsigned DATA_W_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Response bundle at the default data width
    typedef struct packed {
        logic [DATA_W_DFLT-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } apb_rsp_t;

    // Wait counter width: enough to hold the limit itself, never less than 1 bit
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; flags expiry on the wait cycle that reaches TIMEOUT.
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic pclk,
    input  logic preset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count enabled wait cycles up to the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expire on the wait cycle whose increment lands on TIMEOUT; TIMEOUT=0 never expires
    assign expired = (TIMEOUT != 0) && enable && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command/response port to APB master, with pclken gating and wait timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DFLT,
    parameter int unsigned DATA_W  = DATA_W_DFLT,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pclken,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e state_q;
    apb_state_e state_d;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              timeout_q;

    logic accept;
    logic complete;
    logic wait_en;
    logic expired;

    assign accept   = (state_q == IDLE) && cmd_valid;
    assign complete = (state_q == ACCESS) && pclken && pready;
    assign wait_en  = (state_q == ACCESS) && pclken && !pready;

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .pclk    (pclk),
        .preset  (preset),
        .clear   (accept),
        .enable  (wait_en),
        .expired (expired)
    );

    // State register
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; SETUP and ACCESS only advance on pclken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_valid) state_d = SETUP;
            SETUP:   if (pclken) state_d = ACCESS;
            ACCESS:  if (complete || expired) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs decoded from state
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            // Masked by preset so the port reads not-ready while reset is held
            IDLE:    cmd_ready = !preset;
            SETUP:   psel = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latch; holds last transfer values between transfers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else if (accept) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_write ? cmd_wdata : '0;
        end
    end

    // Response capture on completion or abort; held through RESP
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (complete) begin
            rdata_q   <= pwrite_q ? '0 : prdata;
            err_q     <= pslverr;
            timeout_q <= 1'b0;
        end else if (expired) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
        end
    end

    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

endmodule
